// File: rtl/ram_access_master_if.sv
// CPU-side request/response and byte-wide RAM signals of ram_access_master.
// The master modport is the block itself; slave is the CPU plus RAM side.
interface ram_access_master_if #(
    parameter int WIDTH_ADDRESS = 20,
    parameter int WIDTH_DATA    = 8
);
    logic                     req_valid;
    logic                     req_ready;
    logic                     req_write;
    logic                     req_word;
    logic [WIDTH_ADDRESS-1:0] req_address;
    logic [15:0]              req_wdata;
    logic                     resp_valid;
    logic [15:0]              resp_rdata;
    logic                     resp_error;
    logic                     ram_read_enable;
    logic [WIDTH_ADDRESS-1:0] ram_read_address;
    logic [WIDTH_DATA-1:0]    ram_read_data;
    logic                     ram_write_enable;
    logic [WIDTH_ADDRESS-1:0] ram_write_address;
    logic [WIDTH_DATA-1:0]    ram_write_data;

    modport master (
        input  req_valid, req_write, req_word, req_address, req_wdata, ram_read_data,
        output req_ready, resp_valid, resp_rdata, resp_error,
        output ram_read_enable, ram_read_address,
        output ram_write_enable, ram_write_address, ram_write_data
    );

    modport slave (
        output req_valid, req_write, req_word, req_address, req_wdata, ram_read_data,
        input  req_ready, resp_valid, resp_rdata, resp_error,
        input  ram_read_enable, ram_read_address,
        input  ram_write_enable, ram_write_address, ram_write_data
    );
endinterface

// File: rtl/ram_access_master.sv
// Splits 8086-style byte/word requests into one or two byte-wide RAM accesses.
// Optional macro RAM_ACCESS_MASTER_ALIGN_CHECK_EN rejects odd-address word requests.
module ram_access_master #(
    parameter int WIDTH_ADDRESS = 20,
    parameter int WIDTH_DATA    = 8,    // must be 8
    parameter int READ_LATENCY  = 1     // 1..4
) (
    input  logic                clock,
    input  logic                reset,
    ram_access_master_if.master bus
);
    typedef enum logic [2:0] {
        IDLE, WR_LO, WR_HI, RD_LO, WAIT_LO, RD_HI, WAIT_HI, RESP
    } state_t;

    localparam logic [2:0] LAT_LAST = 3'(READ_LATENCY - 1);

    state_t                   r_state;
    state_t                   w_state_next;
    logic                     r_word;
    logic [WIDTH_ADDRESS-1:0] r_address;
    logic [7:0]               r_wdata_hi;
    logic [2:0]               r_wait_cnt;
    logic [7:0]               r_rdata_lo;
    logic [15:0]              r_resp_rdata;
    logic [WIDTH_ADDRESS-1:0] r_ram_read_address;
    logic [WIDTH_ADDRESS-1:0] r_ram_write_address;
    logic [WIDTH_DATA-1:0]    r_ram_write_data;
    logic                     w_req_ready;
    logic                     w_resp_valid;
    logic                     w_rd_en;
    logic                     w_wr_en;
    logic                     w_accept;
    logic                     w_reject;
    logic                     w_wait_done;

`ifdef RAM_ACCESS_MASTER_ALIGN_CHECK_EN
    logic r_resp_error;
    assign w_reject        = bus.req_word & bus.req_address[0];
    assign bus.resp_error  = w_resp_valid & r_resp_error;
`else
    assign w_reject        = 1'b0;
    assign bus.resp_error  = 1'b0;
`endif

    assign w_accept    = w_req_ready & bus.req_valid;
    assign w_wait_done = (r_wait_cnt == LAT_LAST);

    // NOTE: every output of this block gets a default first so no path can infer a latch.
    always_comb begin
        w_state_next = r_state;
        w_req_ready  = 1'b0;
        w_resp_valid = 1'b0;
        w_rd_en      = 1'b0;
        w_wr_en      = 1'b0;
        case (r_state)
            IDLE: begin
                w_req_ready = 1'b1;
                if (bus.req_valid) begin
                    if (w_reject)           w_state_next = RESP;
                    else if (bus.req_write) w_state_next = WR_LO;
                    else                    w_state_next = RD_LO;
                end
            end
            WR_LO: begin
                w_wr_en      = 1'b1;
                w_state_next = r_word ? WR_HI : RESP;
            end
            WR_HI: begin
                w_wr_en      = 1'b1;
                w_state_next = RESP;
            end
            RD_LO: begin
                w_rd_en      = 1'b1;
                w_state_next = WAIT_LO;
            end
            WAIT_LO: if (w_wait_done) w_state_next = r_word ? RD_HI : RESP;
            RD_HI: begin
                w_rd_en      = 1'b1;
                w_state_next = WAIT_HI;
            end
            WAIT_HI: if (w_wait_done) w_state_next = RESP;
            RESP: begin
                w_resp_valid = 1'b1;
                w_state_next = IDLE;
            end
            default: w_state_next = IDLE;
        endcase
    end

    // NOTE: all state is updated with non-blocking assignments so every flop sees pre-edge values.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) r_state <= IDLE;
        else        r_state <= w_state_next;
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_word              <= 1'b0;
            r_address           <= '0;
            r_wdata_hi          <= '0;
            r_wait_cnt          <= '0;
            r_rdata_lo          <= '0;
            r_resp_rdata        <= '0;
            r_ram_read_address  <= '0;
            r_ram_write_address <= '0;
            r_ram_write_data    <= '0;
`ifdef RAM_ACCESS_MASTER_ALIGN_CHECK_EN
            r_resp_error        <= 1'b0;
`endif
        end else begin
            if (w_accept) begin
                r_word     <= bus.req_word;
                r_address  <= bus.req_address;
                r_wdata_hi <= bus.req_wdata[15:8];
`ifdef RAM_ACCESS_MASTER_ALIGN_CHECK_EN
                r_resp_error <= w_reject;
`endif
                if (!w_reject) begin
                    if (bus.req_write) begin
                        r_ram_write_address <= bus.req_address;
                        r_ram_write_data    <= bus.req_wdata[7:0];
                    end else begin
                        r_ram_read_address  <= bus.req_address;
                    end
                end
            end

            // High byte goes to the next address, wrapping past all-ones.
            if (r_state == WR_LO && r_word) begin
                r_ram_write_address <= r_address + 1'b1;
                r_ram_write_data    <= r_wdata_hi;
            end
            if (r_state == WAIT_LO && w_wait_done && r_word)
                r_ram_read_address <= r_address + 1'b1;

            if ((r_state == WAIT_LO || r_state == WAIT_HI) && !w_wait_done)
                r_wait_cnt <= r_wait_cnt + 1'b1;
            else
                r_wait_cnt <= '0;

            if (r_state == WAIT_LO && w_wait_done) begin
                r_rdata_lo <= bus.ram_read_data;
                if (!r_word) r_resp_rdata <= {8'h00, bus.ram_read_data};
            end
            if (r_state == WAIT_HI && w_wait_done)
                r_resp_rdata <= {bus.ram_read_data, r_rdata_lo};
        end
    end

    assign bus.req_ready         = w_req_ready & reset;
    assign bus.resp_valid        = w_resp_valid;
    assign bus.resp_rdata        = r_resp_rdata;
    assign bus.ram_read_enable   = w_rd_en;
    assign bus.ram_read_address  = r_ram_read_address;
    assign bus.ram_write_enable  = w_wr_en;
    assign bus.ram_write_address = r_ram_write_address;
    assign bus.ram_write_data    = r_ram_write_data;
endmodule

// File: tb/tb_ram_access_master.sv
// Randomized bench for ram_access_master: byte-RAM responder, request-level reference model.
// Odd-word rejection tests are active when RAM_ACCESS_MASTER_ALIGN_CHECK_EN is defined.
module tb_ram_access_master;
    localparam int WA  = 20;
    localparam int LAT = 1;

    typedef struct {
        bit          wr;
        logic [WA-1:0] addr;
        logic [7:0]  data;
        int          edge_i;
    } strobe_t;

    logic clock = 1'b0;
    logic reset = 1'b0;
    always #5 clock = ~clock;

    ram_access_master_if #(.WIDTH_ADDRESS(WA), .WIDTH_DATA(8)) bus ();

    ram_access_master #(
        .WIDTH_ADDRESS(WA), .WIDTH_DATA(8), .READ_LATENCY(LAT)
    ) dut (
        .clock(clock),
        .reset(reset),
        .bus  (bus.master)
    );

    int total = 0;
    int bad   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Byte RAM seen by the DUT and the contents the requests should have produced.
    bit [7:0] ram_mem [int];
    bit [7:0] ref_mem [int];
    logic [15:0] ref_rdata = 16'h0000;

    function automatic bit [7:0] ram_get(input logic [WA-1:0] a);
        return ram_mem.exists(int'(a)) ? ram_mem[int'(a)] : 8'h00;
    endfunction

    function automatic bit [7:0] ref_get(input logic [WA-1:0] a);
        return ref_mem.exists(int'(a)) ? ref_mem[int'(a)] : 8'h00;
    endfunction

    int            cyc = 0;
    int            both_cnt = 0;
    strobe_t       log_q[$];
    logic          cap_we = 1'b0, cap_re = 1'b0;
    logic [WA-1:0] cap_wa = '0, cap_ra = '0;
    logic [7:0]    cap_wd = '0;
    logic [7:0]    rd_pipe [LAT];

    // Strobes are captured mid-cycle and acted on at the following rising edge.
    always @(negedge clock) begin
        cap_we = bus.ram_write_enable;
        cap_re = bus.ram_read_enable;
        cap_wa = bus.ram_write_address;
        cap_ra = bus.ram_read_address;
        cap_wd = bus.ram_write_data;
        if (cap_we && cap_re) both_cnt++;
        if (cap_we) log_q.push_back('{wr: 1'b1, addr: cap_wa, data: cap_wd, edge_i: cyc + 1});
        if (cap_re) log_q.push_back('{wr: 1'b0, addr: cap_ra, data: 8'h00, edge_i: cyc + 1});
    end

    always @(posedge clock) begin
        cyc <= cyc + 1;
        if (cap_we) ram_mem[int'(cap_wa)] = cap_wd;
        rd_pipe[0] <= cap_re ? ram_get(cap_ra) : 8'($urandom);
        for (int k = 1; k < LAT; k++) rd_pipe[k] <= rd_pipe[k-1];
    end

    assign bus.ram_read_data = rd_pipe[LAT-1];

    task automatic run_req(input string tag, input bit wr, input bit word,
                           input logic [WA-1:0] addr, input logic [15:0] wdata, input bit poke);
        strobe_t       exp_q[$];
        logic [WA-1:0] addr_hi;
        logic [15:0]   exp_rdata;
        bit            reject;
        bit            got;
        int            a_edge, exp_lat, lat, n, ready_seen;
        addr_hi = addr + 1'b1;
        reject  = 1'b0;
`ifdef RAM_ACCESS_MASTER_ALIGN_CHECK_EN
        reject = word && addr[0];
`endif
        exp_rdata = ref_rdata;
        if (reject) begin
            exp_lat = 1;
        end else if (wr) begin
            exp_lat = word ? 3 : 2;
            exp_q.push_back('{wr: 1'b1, addr: addr, data: wdata[7:0], edge_i: 1});
            if (word) exp_q.push_back('{wr: 1'b1, addr: addr_hi, data: wdata[15:8], edge_i: 2});
        end else begin
            exp_lat = word ? 3 + 2 * LAT : 2 + LAT;
            exp_rdata = word ? {ref_get(addr_hi), ref_get(addr)} : {8'h00, ref_get(addr)};
            exp_q.push_back('{wr: 1'b0, addr: addr, data: 8'h00, edge_i: 1});
            if (word) exp_q.push_back('{wr: 1'b0, addr: addr_hi, data: 8'h00, edge_i: 2 + LAT});
        end

        @(negedge clock);
        bus.req_valid   = 1'b1;
        bus.req_write   = wr;
        bus.req_word    = word;
        bus.req_address = addr;
        bus.req_wdata   = wdata;
        n = 0;
        while (!bus.req_ready && n < 20) begin
            @(negedge clock);
            n++;
        end
        if (!bus.req_ready) begin
            check({tag, " accept"}, 0, 1);
            bus.req_valid = 1'b0;
            return;
        end
        a_edge = cyc + 1;
        log_q.delete();

        @(negedge clock);
        // Changed fields after acceptance; with poke a second request stays pending.
        bus.req_valid   = poke;
        bus.req_write   = 1'b1;
        bus.req_word    = 1'($urandom);
        bus.req_address = WA'($urandom);
        bus.req_wdata   = 16'($urandom);
        got = 1'b0;
        lat = 0;
        ready_seen = 0;
        for (int i = 0; i < 40; i++) begin
            if (bus.resp_valid) begin
                got = 1'b1;
                lat = cyc + 1 - a_edge;
                break;
            end
            if (bus.req_ready) ready_seen++;
            @(negedge clock);
        end
        bus.req_valid = 1'b0;
        check({tag, " resp_valid"}, got, 1);
        if (!got) return;
        check({tag, " latency"}, lat, exp_lat);
        check({tag, " resp_error"}, bus.resp_error, reject);
        check({tag, " resp_rdata"}, bus.resp_rdata, exp_rdata);
        check({tag, " busy_ready"}, ready_seen, 0);
        check({tag, " strobe_count"}, log_q.size(), exp_q.size());
        for (int i = 0; i < exp_q.size() && i < log_q.size(); i++) begin
            check($sformatf("%s strobe%0d_wr", tag, i), log_q[i].wr, exp_q[i].wr);
            check($sformatf("%s strobe%0d_addr", tag, i), log_q[i].addr, exp_q[i].addr);
            check($sformatf("%s strobe%0d_data", tag, i), log_q[i].data, exp_q[i].data);
            check($sformatf("%s strobe%0d_cycle", tag, i), log_q[i].edge_i - a_edge, exp_q[i].edge_i);
        end

        ref_rdata = exp_rdata;
        if (wr && !reject) begin
            ref_mem[int'(addr)] = wdata[7:0];
            if (word) ref_mem[int'(addr_hi)] = wdata[15:8];
        end

        @(negedge clock);
        check({tag, " resp_pulse"}, bus.resp_valid, 0);
        check({tag, " ready_after"}, bus.req_ready, 1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog total=%0d bad=%0d", total, bad);
        $fatal(1, "timeout");
    end

    initial begin
        int n;
        logic [WA-1:0] a;
        bus.req_valid   = 1'b0;
        bus.req_write   = 1'b0;
        bus.req_word    = 1'b0;
        bus.req_address = '0;
        bus.req_wdata   = '0;

        #2;
        check("rst req_ready", bus.req_ready, 0);
        check("rst resp_valid", bus.resp_valid, 0);
        check("rst enables", {bus.ram_read_enable, bus.ram_write_enable}, 0);
        repeat (3) @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        check("idle req_ready", bus.req_ready, 1);
        check("idle resp_rdata", bus.resp_rdata, 0);
        check("idle ram_addr", {bus.ram_read_address, bus.ram_write_address}, 0);
        check("idle ram_wdata", bus.ram_write_data, 0);

        run_req("bwr_1", 1'b1, 1'b0, 20'h00001, 16'h00A5, 1'b0);
        run_req("brd_1", 1'b0, 1'b0, 20'h00001, 16'h0000, 1'b0);
        run_req("wwr_10", 1'b1, 1'b1, 20'h00010, 16'hBEEF, 1'b0);
        run_req("wrd_10", 1'b0, 1'b1, 20'h00010, 16'h0000, 1'b0);
        run_req("wwr_wrap", 1'b1, 1'b1, 20'hFFFFF, 16'h1234, 1'b0);
        run_req("wrd_wrap", 1'b0, 1'b1, 20'hFFFFF, 16'h0000, 1'b0);
        run_req("brd_0", 1'b0, 1'b0, 20'h00000, 16'h0000, 1'b0);
        run_req("poke_wrd", 1'b0, 1'b1, 20'h00010, 16'h0000, 1'b1);

        // Reset while the high byte of a word write is on the bus.
        @(negedge clock);
        check("rstmid ready", bus.req_ready, 1);
        bus.req_valid   = 1'b1;
        bus.req_write   = 1'b1;
        bus.req_word    = 1'b1;
        bus.req_address = 20'h00020;
        bus.req_wdata   = 16'hCAFE;
        @(negedge clock);
        bus.req_valid = 1'b0;
        @(posedge clock);
        #1;
        reset = 1'b0;
        #1;
        check("rstmid req_ready", bus.req_ready, 0);
        check("rstmid resp_valid", bus.resp_valid, 0);
        check("rstmid enables", {bus.ram_read_enable, bus.ram_write_enable}, 0);
        check("rstmid ram_addr", {bus.ram_read_address, bus.ram_write_address}, 0);
        check("rstmid ram_wdata", bus.ram_write_data, 0);
        check("rstmid resp_rdata", bus.resp_rdata, 0);
        n = 0;
        repeat (3) begin
            @(negedge clock);
            if (bus.resp_valid) n++;
        end
        check("rstmid no_resp", n, 0);
        reset = 1'b1;
        ref_mem[32'h20] = 8'hFE;
        ref_rdata = 16'h0000;
        run_req("rstmid_brd", 1'b0, 1'b0, 20'h00020, 16'h0000, 1'b0);
        run_req("rstmid_wrd", 1'b0, 1'b1, 20'h00020, 16'h0000, 1'b0);

`ifdef RAM_ACCESS_MASTER_ALIGN_CHECK_EN
        run_req("align_wwr", 1'b1, 1'b1, 20'h00003, 16'h5A5A, 1'b0);
        run_req("align_wrd", 1'b0, 1'b1, 20'h00003, 16'h0000, 1'b0);
        run_req("align_brd", 1'b0, 1'b0, 20'h00003, 16'h0000, 1'b0);
`endif

        for (int i = 0; i < 80; i++) begin
            case ($urandom_range(0, 3))
                0:       a = WA'($urandom);
                1:       a = 20'hFFFFE + WA'($urandom_range(0, 1));
                default: a = WA'($urandom_range(0, 15));
            endcase
            run_req($sformatf("rnd%0d", i), 1'($urandom), 1'($urandom), a,
                    16'($urandom), 1'($urandom_range(0, 1)));
        end

        check("enables_exclusive", both_cnt, 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/ram_access_master.md
Name: ram_access_master

Overview:
- Initiator side of the RAM interface. Drives read_enable/read_address/write_enable/write_address/write_data toward the byte-wide RAM responder and consumes its read_data.
- Turns CPU-side 8086-style byte/word requests (20-bit physical address, 16-bit little-endian data) into one or two byte-wide RAM accesses.
- Sits between the bus interface unit and the RAM.

Parameters:
- WIDTH_ADDRESS, 20, physical address width; address arithmetic wraps modulo 2^WIDTH_ADDRESS.
- WIDTH_DATA, 8, RAM data width; the block requires exactly 8.
- READ_LATENCY, 1, cycles from read_enable sampled high to read_data valid; legal range 1..4.

Ports:
- clock  in  1  rising-edge clock
- reset  in  1  asynchronous, active-low reset
- req_valid  in  1  request present
- req_ready  out  1  block can accept a request
- req_write  in  1  1 = write, 0 = read
- req_word  in  1  1 = 16-bit access, 0 = byte access
- req_address  in  WIDTH_ADDRESS  byte address
- req_wdata  in  16  write data; byte access uses [7:0]
- resp_valid  out  1  one-cycle completion pulse
- resp_rdata  out  16  read result, valid with resp_valid
- resp_error  out  1  request rejected, valid with resp_valid
- ram_read_enable  out  1  RAM read strobe
- ram_read_address  out  WIDTH_ADDRESS  RAM read address
- ram_read_data  in  WIDTH_DATA  RAM read data
- ram_write_enable  out  1  RAM write strobe
- ram_write_address  out  WIDTH_ADDRESS  RAM write address
- ram_write_data  out  WIDTH_DATA  RAM write data

Behaviour:
- Reset (reset low, asynchronous):
  - state = IDLE.
  - All outputs 0, except req_ready = 1 once reset is released.
  - Wait counter cleared.
- States: IDLE, WR_LO, WR_HI, RD_LO, WAIT_LO, RD_HI, WAIT_HI, RESP.
- Handshake:
  - req_ready = 1 only in IDLE.
  - Accept on the rising edge where req_valid && req_ready (call this cycle A).
  - Request fields are registered at A; later changes on req_* are ignored.
- Write:
  - A+1: WR_LO; ram_write_enable = 1, address = addr, data = wdata[7:0].
  - Word access only, A+2: WR_HI; address = addr+1 (wraps to 0 after all-ones), data = wdata[15:8].
  - Then RESP: resp_valid = 1, resp_error = 0. Byte completes at A+2, word at A+3.
- Read:
  - A+1: RD_LO; ram_read_enable = 1 for one cycle, address = addr.
  - WAIT_LO: counts READ_LATENCY cycles, then captures ram_read_data into the low byte.
  - Word access only: RD_HI issues addr+1 (wrapped), WAIT_HI captures the high byte the same way.
  - RESP drives resp_valid = 1. For READ_LATENCY = 1: byte at A+3, word at A+5.
- Read data formatting:
  - Byte read: resp_rdata = {8'h00, byte}.
  - Word read: resp_rdata = {high, low}.
- RESP lasts one cycle, then IDLE. resp_valid is never held and there is no response backpressure. The earliest next accept is the cycle after RESP.
- ram_read_enable and ram_write_enable are each high one cycle per byte access and are never both high.
- RAM address and data outputs are registered and hold their last value while the enables are low.
- resp_rdata holds its value until the next read completes. Write responses leave resp_rdata unchanged.
- Reset mid-operation: immediate return to IDLE with outputs cleared. An in-flight response is dropped. A word write may leave only the low byte written; this is accepted behaviour.
- req_valid while busy: ignored, with no side effects. The requester holds req_valid until it sees req_ready.

Optional Feature:
- Macro: RAM_ACCESS_MASTER_ALIGN_CHECK_EN.
- Defined:
  - A word request with req_address[0] = 1 is rejected.
  - No RAM strobes are issued.
  - A+1 is RESP with resp_valid = 1, resp_error = 1, resp_rdata unchanged.
- Undefined:
  - Odd-address word requests are split into two byte accesses as described in Behaviour.
  - resp_error is tied to 0.

Test Plan:
- Byte write addr 20'h00001, wdata 16'h00A5, then byte read 20'h00001 -> one write strobe at A+1 with address 20'h00001 and data 8'hA5; resp_valid at A+2; read resp_rdata = 16'h00A5 at A+3 (READ_LATENCY = 1).
- Word write 20'h00010, wdata 16'hBEEF, then word read 20'h00010 -> write strobes 8'hEF @ 20'h00010 then 8'hBE @ 20'h00011 on consecutive cycles; read resp_rdata = 16'hBEEF at A+5.
- Word write 20'hFFFFF, wdata 16'h1234 (macro off) -> 8'h34 @ 20'hFFFFF, 8'h12 @ 20'h00000; word read returns 16'h1234.
- Pulse req_valid with a different request during a word read -> req_ready stays 0; the second request is not accepted until after RESP; the first read's resp_rdata is unaffected.
- Assert reset during WR_HI of word write 16'hCAFE @ 20'h00020 -> no resp_valid; all outputs 0 asynchronously; a subsequent byte read of 20'h00020 returns 16'h00FE.
- Macro on: word read at 20'h00003 -> no RAM strobes; resp_valid = 1 and resp_error = 1 at A+1; a byte read at 20'h00003 still succeeds with resp_error = 0.
